// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// One shift-add or restoring shift-subtract step per cycle; sign fix-up in a final cycle.
module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic                  cancel_i,
    input  logic                  hi_we_i,
    input  logic                  lo_we_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_zero_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic          neg_q;
    logic          neg_r;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opb;
    logic [W-1:0]  rs_raw;

    logic          is_signed;
    logic          neg_a;
    logic          neg_b;
    logic [W-1:0]  mag_rs;
    logic [W-1:0]  mag_rt;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ok;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;
    logic          div_by_zero;
    logic          accept;

    always_comb begin
        is_signed = ~op_i[0];
        neg_a     = is_signed & rs_data_i[W-1];
        neg_b     = is_signed & rt_data_i[W-1];
        mag_rs    = neg_a ? (~rs_data_i + 1'b1) : rs_data_i;
        mag_rt    = neg_b ? (~rt_data_i + 1'b1) : rt_data_i;
        accept    = (state == IDLE) & start_i & ~cancel_i;
    end

    // Multiply: acc_lo holds the multiplier and fills with product bits from the top.
    // Divide: acc_lo holds the dividend and fills with quotient bits from the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = ~div_diff[W];
    end

    always_comb begin
        prod_fix    = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        q_fix       = neg_q ? (~acc_lo + 1'b1) : acc_lo;
        r_fix       = neg_r ? (~acc_hi + 1'b1) : acc_hi;
        div_by_zero = is_div & (opb == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            rs_raw     <= '0;
            hi_o       <= '0;
            lo_o       <= '0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we_i) hi_o <= wr_data_i;
                    if (lo_we_i) lo_o <= wr_data_i;
                    if (accept) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_div <= op_i[1];
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        acc_hi <= '0;
                        rs_raw <= rs_data_i;
                        acc_lo <= op_i[1] ? mag_rs : mag_rt;
                        opb    <= op_i[1] ? mag_rt : mag_rs;
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
                            acc_lo <= {acc_lo[W-2:0], div_ok};
                        end else begin
                            acc_hi <= mul_sum[W:1];
                            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!cancel_i) begin
                        done_o <= 1'b1;
                        if (div_by_zero) begin
                            lo_o       <= '1;
                            hi_o       <= rs_raw;
                            div_zero_o <= 1'b1;
                        end else if (is_div) begin
                            lo_o <= q_fix;
                            hi_o <= r_fix;
                        end else begin
                            {hi_o, lo_o} <= prod_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (W=32).
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        cancel_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wr_data_i;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_data_i  (rs_data_i),
        .rt_data_i  (rt_data_i),
        .cancel_i   (cancel_i),
        .hi_we_i    (hi_we_i),
        .lo_we_i    (lo_we_i),
        .wr_data_i  (wr_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launches one operation, optionally pulses mthi at cycle mthi_at, and returns at the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mthi_at, output int lat, output int busy_n);
        bit got;
        got = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        busy_n = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (done_o) begin
                got = 1;
                break;
            end
            lat++;
            if (busy_o) busy_n++;
            if (k == mthi_at) begin
                hi_we_i = 1'b1; wr_data_i = 32'h0000_1234;
            end else begin
                hi_we_i = 1'b0;
            end
        end
        hi_we_i = 1'b0;
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int busy_n;
    int n_done;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    initial begin
        reset = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
        cancel_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; wr_data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_dz", {31'd0, div_zero_o}, 32'd0);

        // mult 7 x -3
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, lat, busy_n);
        check("mult_lat", lat, 32'd33);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFEB);
        check("mult_dz", {31'd0, div_zero_o}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, done_o}, 32'd0);

        // multu max x max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, busy_n);
        check("multu_busy", busy_n, 32'd33);
        check("multu_hi", hi_o, 32'hFFFF_FFFE);
        check("multu_lo", lo_o, 32'h0000_0001);

        // div -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, busy_n);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        // signed overflow
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_n);
        check("ovf_lo", lo_o, 32'h8000_0000);
        check("ovf_hi", hi_o, 32'h0);

        // divu 5 / 0 with mthi while busy
        run_op(2'b11, 32'd5, 32'd0, 5, lat, busy_n);
        check("dz_lo", lo_o, 32'hFFFF_FFFF);
        check("dz_hi", hi_o, 32'h0000_0005);
        check("dz_flag", {31'd0, div_zero_o}, 32'd1);
        @(negedge clk);
        check("dz_pulse", {31'd0, div_zero_o}, 32'd0);

        // divu 100 / 7 cancelled at cycle 10
        start_i = 1'b1; op_i = 2'b11; rs_data_i = 32'd100; rt_data_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_busy", {31'd0, busy_o}, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) n_done++;
        end
        check("cancel_ndone", n_done, 32'd0);
        check("cancel_hi", hi_o, 32'h0000_0005);
        check("cancel_lo", lo_o, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd7, 0, lat, busy_n);
        check("divu_lo", lo_o, 32'h0000_000E);
        check("divu_hi", hi_o, 32'h0000_0002);

        // mtlo in idle, visible only after the edge
        @(negedge clk);
        lo_we_i = 1'b1; wr_data_i = 32'hCAFE_0001;
        @(negedge clk);
        lo_we_i = 1'b0;
        check("mtlo", lo_o, 32'hCAFE_0001);
        check("mtlo_hi_kept", hi_o, 32'h0000_0002);

        // reset at cycle 5 of a mult
        start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'd9; rt_data_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_hi", hi_o, 32'h0);
        check("mrst_lo", lo_o, 32'h0);
        check("mrst_busy", {31'd0, busy_o}, 32'd0);

        // start pulsed while busy is ignored
        start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'd3; rt_data_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'd2; rt_data_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        n_done = 0;
        cap_hi = 32'hDEAD_BEEF;
        cap_lo = 32'hDEAD_BEEF;
        repeat (80) begin
            @(negedge clk);
            if (done_o) begin
                n_done++;
                cap_hi = hi_o;
                cap_lo = lo_o;
            end
        end
        check("ign_ndone", n_done, 32'd1);
        check("ign_lo", cap_lo, 32'd12);
        check("ign_hi", cap_hi, 32'd0);

        // back-to-back: new start accepted in the done cycle
        run_op(2'b00, 32'd2, 32'd3, 0, lat, busy_n);
        check("b2b_first", lo_o, 32'd6);
        start_i = 1'b1; op_i = 2'b01; rs_data_i = 32'd5; rt_data_i = 32'd6;
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_busy", {31'd0, busy_o}, 32'd1);
        n_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_o) begin
                n_done = 1;
                break;
            end
        end
        check("b2b_done", n_done, 32'd1);
        check("b2b_lo", lo_o, 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
